// File: rtl/reset_seq_pkg.sv
// Shared types, defaults and sizing helper for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    ASSERT,
    STAGGER,
    READY
  } rs_state_t;

  localparam int unsigned DEF_ROC_CYCLES = 16;
  localparam int unsigned DEF_TOC_CYCLES = 4;
  localparam int unsigned DEF_NUM_STAGES = 3;
  localparam int unsigned DEF_STAGE_GAP  = 8;

  function automatic int unsigned cnt_w(input int unsigned roc, input int unsigned gap);
    int unsigned m;
    m = (roc > gap) ? roc : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Cycle-accurate global/staged reset release controller gated by clock lock.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned ROC_CYCLES = DEF_ROC_CYCLES,
  parameter int unsigned TOC_CYCLES = DEF_TOC_CYCLES,
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
  parameter int unsigned STAGE_GAP  = DEF_STAGE_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock_in,
  input  logic                  soft_req,
  output logic                  gsr_o,
  output logic                  prld_o,
  output logic                  gts_o,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  busy_o,
  output logic                  ready_o
);

  localparam int unsigned CW = cnt_w(ROC_CYCLES, STAGE_GAP);
  localparam logic [CW-1:0] TOC_C = CW'(TOC_CYCLES);
  localparam logic [CW-1:0] ROC_C = CW'(ROC_CYCLES);
  localparam logic [CW-1:0] GAP_C = CW'(STAGE_GAP);

  if (ROC_CYCLES < 1) begin : g_bad_roc
    $error("reset_sequencer: ROC_CYCLES must be >= 1");
  end
  if (TOC_CYCLES < 1 || TOC_CYCLES > ROC_CYCLES) begin : g_bad_toc
    $error("reset_sequencer: TOC_CYCLES must be in 1..ROC_CYCLES");
  end
  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
    $error("reset_sequencer: NUM_STAGES must be in 1..8");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("reset_sequencer: STAGE_GAP must be >= 1");
  end

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock_in),
    .q   (lock_s)
  );

  rs_state_t             state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt, cnt_inc;
  logic                  gsr_nxt, gts_nxt, busy_nxt, ready_nxt;
  logic [NUM_STAGES-1:0] stage_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      gsr_o       <= 1'b1;
      gts_o       <= 1'b1;
      stage_rst_o <= '1;
      busy_o      <= 1'b0;
      ready_o     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      gsr_o       <= gsr_nxt;
      gts_o       <= gts_nxt;
      stage_rst_o <= stage_nxt;
      busy_o      <= busy_nxt;
      ready_o     <= ready_nxt;
    end
  end

  assign prld_o = gsr_o;

  // Outputs are computed from the next counter value so each release lands
  // on the same edge the counter reaches its threshold.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gsr_nxt   = gsr_o;
    gts_nxt   = gts_o;
    stage_nxt = stage_rst_o;
    busy_nxt  = busy_o;
    ready_nxt = ready_o;
    cnt_inc   = cnt + CW'(1);

    if (!lock_s) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
      gsr_nxt   = 1'b1;
      gts_nxt   = 1'b1;
      stage_nxt = '1;
      busy_nxt  = 1'b0;
      ready_nxt = 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state_nxt = ASSERT;
          cnt_nxt   = '0;
          gsr_nxt   = 1'b1;
          gts_nxt   = 1'b1;
          stage_nxt = '1;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
        end
        ASSERT: begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == TOC_C) gts_nxt = 1'b0;
          if (cnt_inc == ROC_C) begin
            gsr_nxt   = 1'b0;
            state_nxt = STAGGER;
            cnt_nxt   = '0;
          end
        end
        STAGGER: begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == GAP_C) begin
            stage_nxt = stage_rst_o << 1;
            cnt_nxt   = '0;
            if (stage_nxt == '0) begin
              state_nxt = READY;
              busy_nxt  = 1'b0;
              ready_nxt = 1'b1;
            end
          end
        end
        READY: begin
          if (soft_req) begin
            state_nxt = ASSERT;
            cnt_nxt   = '0;
            gsr_nxt   = 1'b1;
            gts_nxt   = 1'b1;
            stage_nxt = '1;
            busy_nxt  = 1'b1;
            ready_nxt = 1'b0;
          end
        end
        default: state_nxt = WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: default and boundary-parameter sequencers against a timestamp model.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       lock_in;
  logic       soft_req;

  logic       a_gsr, a_prld, a_gts, a_busy, a_ready;
  logic [2:0] a_stage;
  logic       b_gsr, b_prld, b_gts, b_busy, b_ready;
  logic [0:0] b_stage;

  reset_sequencer u_a (
    .clk         (clk),
    .rst         (rst),
    .lock_in     (lock_in),
    .soft_req    (soft_req),
    .gsr_o       (a_gsr),
    .prld_o      (a_prld),
    .gts_o       (a_gts),
    .stage_rst_o (a_stage),
    .busy_o      (a_busy),
    .ready_o     (a_ready)
  );

  reset_sequencer #(
    .ROC_CYCLES (1),
    .TOC_CYCLES (1),
    .NUM_STAGES (1),
    .STAGE_GAP  (1)
  ) u_b (
    .clk         (clk),
    .rst         (rst),
    .lock_in     (lock_in),
    .soft_req    (soft_req),
    .gsr_o       (b_gsr),
    .prld_o      (b_prld),
    .gts_o       (b_gts),
    .stage_rst_o (b_stage),
    .busy_o      (b_busy),
    .ready_o     (b_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned failed = 0;
  int          n      = 0;

  // Reference model: lock sample history plus, per instance, the edge at which
  // the current sequence started; outputs follow from elapsed cycles.
  bit s1 = 1'b0, s2 = 1'b0;
  bit a_act = 1'b0, b_act = 1'b0;
  int a_start = 0, b_start = 0;

  function automatic logic [12:0] exp_out(input bit act, input int k, input int toc,
                                          input int roc, input int ns, input int gap);
    logic [7:0] st;
    logic       gs, gt, rdy;
    if (!act) return {3'b111, 2'b00, 8'((1 << ns) - 1)};
    gs  = (k < roc);
    gt  = (k < toc);
    rdy = (k >= roc + ns * gap);
    st  = '0;
    for (int j = 0; j < ns; j++) st[j] = (k < roc + (j + 1) * gap);
    return {gs, gs, gt, !rdy, rdy, st};
  endfunction

  task automatic seq_step(inout bit act, inout int st, input int tot, input bit ls);
    if (rst || !ls) act = 1'b0;
    else if (!act) begin
      act = 1'b1;
      st  = n;
    end else if ((n - 1 - st) >= tot && soft_req) st = n;
  endtask

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    check(tag, {12'b0, obs}, {12'b0, exp});
  endtask

  task automatic tick();
    bit ls;
    @(posedge clk);
    n++;
    ls = s2;
    if (rst) begin
      s1 = 1'b0;
      s2 = 1'b0;
    end else begin
      s2 = s1;
      s1 = lock_in;
    end
    seq_step(a_act, a_start, 40, ls);
    seq_step(b_act, b_start, 2, ls);
    @(negedge clk);
    check("a_outputs", {a_gsr, a_prld, a_gts, a_busy, a_ready, 5'b0, a_stage},
          exp_out(a_act, n - a_start, 4, 16, 3, 8));
    check("b_outputs", {b_gsr, b_prld, b_gts, b_busy, b_ready, 7'b0, b_stage},
          exp_out(b_act, n - b_start, 1, 1, 1, 1));
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  int t0, t1, lock_low;

  initial begin
    rst      = 1'b1;
    lock_in  = 1'b1;
    soft_req = 1'b0;

    // Power-up with lock already high
    repeat (3) tick();
    chk("rst_gsr", a_gsr, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    t0  = n;
    rst = 1'b0;
    run_to(t0 + 2);  chk("pwr_busy_pre", a_busy, 1'b0);
    run_to(t0 + 3);  chk("pwr_busy_A", a_busy, 1'b1);
    run_to(t0 + 4);  chk("bnd_gts", b_gts, 1'b0); chk("bnd_gsr", b_gsr, 1'b0);
                     chk("bnd_stage_hi", b_stage[0], 1'b1);
    run_to(t0 + 5);  chk("bnd_stage_lo", b_stage[0], 1'b0); chk("bnd_ready", b_ready, 1'b1);
    run_to(t0 + 6);  chk("pwr_gts_hi", a_gts, 1'b1);
    run_to(t0 + 7);  chk("pwr_gts_lo", a_gts, 1'b0);
    run_to(t0 + 18); chk("pwr_gsr_hi", a_gsr, 1'b1);
    run_to(t0 + 19); chk("pwr_gsr_lo", a_gsr, 1'b0); chk("pwr_prld_lo", a_prld, 1'b0);
    run_to(t0 + 27); check("pwr_stage0", {10'b0, a_stage}, 13'b110);
    run_to(t0 + 35); check("pwr_stage1", {10'b0, a_stage}, 13'b100);
    run_to(t0 + 42); chk("pwr_ready_pre", a_ready, 1'b0); chk("pwr_busy_end", a_busy, 1'b1);
    run_to(t0 + 43); chk("pwr_ready", a_ready, 1'b1); chk("pwr_busy_off", a_busy, 1'b0);

    // Soft re-sequence, second pulse during ASSERT is ignored
    run_to(t0 + 99);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("soft_gsr", a_gsr, 1'b1); chk("soft_ready", a_ready, 1'b0);
    run_to(t0 + 103); chk("soft_gts_hi", a_gts, 1'b1);
    run_to(t0 + 104); chk("soft_gts_lo", a_gts, 1'b0);
    run_to(t0 + 109);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    run_to(t0 + 139); chk("soft_ready_pre", a_ready, 1'b0);
    run_to(t0 + 140); chk("soft_ready", a_ready, 1'b1);

    // Lock loss mid-STAGGER
    rst = 1'b1;
    tick();
    t0  = n;
    rst = 1'b0;
    run_to(t0 + 30);
    lock_in = 1'b0;
    run_to(t0 + 32); chk("loss_busy_pre", a_busy, 1'b1);
    run_to(t0 + 33); chk("loss_busy", a_busy, 1'b0); chk("loss_gsr", a_gsr, 1'b1);
                     check("loss_stage", {10'b0, a_stage}, 13'b111);
    run_to(t0 + 45); chk("loss_hold", a_busy, 1'b0);
    lock_in = 1'b1;
    t1 = n;
    run_to(t1 + 3);  chk("relock_busy", a_busy, 1'b1);
    run_to(t1 + 43); chk("relock_ready", a_ready, 1'b1);

    // Late lock
    lock_in = 1'b0;
    rst     = 1'b1;
    repeat (2) tick();
    t0  = n;
    rst = 1'b0;
    run_to(t0 + 50); chk("late_gsr", a_gsr, 1'b1); chk("late_busy", a_busy, 1'b0);
    lock_in = 1'b1;
    run_to(t0 + 52); chk("late_busy_pre", a_busy, 1'b0);
    run_to(t0 + 53); chk("late_busy_A", a_busy, 1'b1);
    run_to(t0 + 92); chk("late_ready_pre", a_ready, 1'b0);
    run_to(t0 + 93); chk("late_ready", a_ready, 1'b1);

    // Mid-sequence reset during ASSERT
    rst = 1'b1;
    tick();
    t0  = n;
    rst = 1'b0;
    run_to(t0 + 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_gts", a_gts, 1'b1); chk("mrst_busy", a_busy, 1'b0);
    run_to(t0 + 18); chk("mrst_busy_pre", a_busy, 1'b0);
    run_to(t0 + 19); chk("mrst_busy_A", a_busy, 1'b1);
    run_to(t0 + 59); chk("mrst_ready", a_ready, 1'b1);

    // Randomized lock glitches, soft requests and resets
    lock_low = 0;
    for (int i = 0; i < 900; i++) begin
      soft_req = ($urandom_range(0, 15) == 0);
      if (lock_low > 0) begin
        lock_low--;
        lock_in = (lock_low == 0);
      end else if ($urandom_range(0, 149) == 0) begin
        lock_in  = 1'b0;
        lock_low = $urandom_range(1, 8);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
